wshb_arbiter2: RTL and testbench

- Two-master, one-slave Wishbone classic arbiter on the 100 MHz Wishbone bus domain.
- Shares the SDRAM slave port between master 0 (VGA framebuffer fetch, feeding the pixel FIFO) and master 1 (framebuffer writer / pattern generator).
- Grants by round-robin at cycle boundaries; a burst-length limit preempts a long-holding master so the VGA FIFO cannot starve.

---
 rtl/wshb_arb_pkg.sv | 30 +++
 rtl/arb_rr2_core.sv | 116 +++++++++++
 rtl/wshb_arbiter2.sv | 98 +++++++++
 tb/tb_wshb_arbiter2.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/wshb_arb_pkg.sv
// rtl/wshb_arb_pkg.sv - shared types and grant encodings for the two-master Wishbone arbiter
//
// Purpose: state enum and one-hot grant constants used by arb_rr2_core and wshb_arbiter2.
// Ports:   none (package).
// Config:  WSHB_ARB_M0_PRIORITY_EN is consumed by arb_rr2_core, not by this package.

package wshb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  function automatic logic [1:0] grant_of(input arb_state_e s);
    logic [1:0] g;
    g = GRANT_NONE;
    case (s)
      GNT0:    g = GRANT_M0;
      GNT1:    g = GRANT_M1;
      default: g = GRANT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/arb_rr2_core.sv
// rtl/arb_rr2_core.sv - grant FSM, round-robin pointer and burst counter for the 2-master arbiter
//
// Purpose: decides which master owns the slave port. Grants change only at
//          Wishbone cycle boundaries, or when the holder has taken MAX_BURST
//          acks while the other master is waiting.
// Ports:
//   clk, rst_n      bus clock, synchronous active-low reset
//   m0_cyc, m1_cyc  master cycle requests
//   m0_ack, m1_ack  acks actually delivered to each master this cycle
//   grant           registered one-hot grant (00 idle, 01 m0, 10 m1)
// Config:
//   WSHB_ARB_M0_PRIORITY_EN  defined: m0 wins every tie and is never preempted;
//                            undefined: symmetric round-robin, both preemptible.

import wshb_arb_pkg::*;

module arb_rr2_core #(
  parameter int MAX_BURST = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m0_cyc,
  input  logic       m1_cyc,
  input  logic       m0_ack,
  input  logic       m1_ack,
  output logic [1:0] grant
);

  // A zero MAX_BURST would give a zero-width counter; keep one bit instead.
  localparam int BCNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [BCNT_W-1:0] BCNT_SAT  = BCNT_W'((MAX_BURST > 0) ? MAX_BURST : 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);
  localparam bit PREEMPT_EN = (MAX_BURST != 0);

  arb_state_e        state_q, state_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [1:0]        grant_q, grant_d;
`ifndef WSHB_ARB_M0_PRIORITY_EN
  logic              last_q, last_d;
`endif

  logic ack_cur;
  logic burst_done;
  arb_state_e tie_pick;

  always_comb begin
    ack_cur    = ((state_q == GNT0) && m0_ack) || ((state_q == GNT1) && m1_ack);
    // The ack that lands on BCNT_LAST is the MAX_BURST-th of this grant.
    burst_done = PREEMPT_EN && (bcnt_q == BCNT_LAST);
`ifdef WSHB_ARB_M0_PRIORITY_EN
    tie_pick   = GNT0;
`else
    tie_pick   = last_q ? GNT0 : GNT1;
`endif
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    grant_d = grant_q;
`ifndef WSHB_ARB_M0_PRIORITY_EN
    last_d  = last_q;
`endif

    case (state_q)
      IDLE: begin
        if (m0_cyc && m1_cyc) state_d = tie_pick;
        else if (m0_cyc)      state_d = GNT0;
        else if (m1_cyc)      state_d = GNT1;
      end
      GNT0: begin
        // Hand straight over on release so the waiting master sees no idle bubble.
        if (!m0_cyc)                                   state_d = m1_cyc ? GNT1 : IDLE;
`ifndef WSHB_ARB_M0_PRIORITY_EN
        else if (m0_ack && burst_done && m1_cyc)       state_d = GNT1;
`endif
      end
      GNT1: begin
        if (!m1_cyc)                                   state_d = m0_cyc ? GNT0 : IDLE;
        else if (m1_ack && burst_done && m0_cyc)       state_d = GNT0;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q)                   bcnt_d = '0;
    else if (ack_cur && (bcnt_q != BCNT_SAT)) bcnt_d = bcnt_q + 1'b1;

`ifndef WSHB_ARB_M0_PRIORITY_EN
    if ((state_d == GNT0) && (state_q != GNT0)) last_d = 1'b0;
    if ((state_d == GNT1) && (state_q != GNT1)) last_d = 1'b1;
`endif

    grant_d = grant_of(state_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      grant_q <= GRANT_NONE;
`ifndef WSHB_ARB_M0_PRIORITY_EN
      last_q  <= 1'b1;  // m0 wins the first tie after reset
`endif
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      grant_q <= grant_d;
`ifndef WSHB_ARB_M0_PRIORITY_EN
      last_q  <= last_d;
`endif
    end
  end

  assign grant = grant_q;

endmodule

// File: rtl/wshb_arbiter2.sv
// rtl/wshb_arbiter2.sv - two-master, one-slave Wishbone classic arbiter (VGA fetch vs framebuffer writer)
//
// Purpose: steers the SDRAM slave port to whichever master arb_rr2_core has
//          granted. The mux is purely combinational from the registered grant.
// Ports:
//   clk, rst_n                      bus clock, synchronous active-low reset
//   mN_cyc/stb/we/adr/sel/dat_ms    master N request side
//   mN_dat_sm, mN_ack               master N response side (read data is broadcast)
//   s_cyc/stb/we/adr/sel/dat_ms     slave request side
//   s_dat_sm, s_ack                 slave response side
//   grant                           one-hot current owner, 00 when idle
// Config:
//   WSHB_ARB_M0_PRIORITY_EN  m0 fixed priority, only m1 is preemptible (see arb_rr2_core)

import wshb_arb_pkg::*;

module wshb_arbiter2 #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_cyc,
  input  logic                m0_stb,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_adr,
  input  logic [DATA_W/8-1:0] m0_sel,
  input  logic [DATA_W-1:0]   m0_dat_ms,
  output logic [DATA_W-1:0]   m0_dat_sm,
  output logic                m0_ack,
  input  logic                m1_cyc,
  input  logic                m1_stb,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_adr,
  input  logic [DATA_W/8-1:0] m1_sel,
  input  logic [DATA_W-1:0]   m1_dat_ms,
  output logic [DATA_W-1:0]   m1_dat_sm,
  output logic                m1_ack,
  output logic                s_cyc,
  output logic                s_stb,
  output logic                s_we,
  output logic [ADDR_W-1:0]   s_adr,
  output logic [DATA_W/8-1:0] s_sel,
  output logic [DATA_W-1:0]   s_dat_ms,
  input  logic [DATA_W-1:0]   s_dat_sm,
  input  logic                s_ack,
  output logic [1:0]          grant
);

  arb_rr2_core #(
    .MAX_BURST (MAX_BURST)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .m0_cyc (m0_cyc),
    .m1_cyc (m1_cyc),
    .m0_ack (m0_ack),
    .m1_ack (m1_ack),
    .grant  (grant)
  );

  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_sel    = '0;
    s_dat_ms = '0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    case (grant)
      GRANT_M0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_sel    = m0_sel;
        s_dat_ms = m0_dat_ms;
        m0_ack   = s_ack & m0_stb & m0_cyc;
      end
      GRANT_M1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_sel    = m1_sel;
        s_dat_ms = m1_dat_ms;
        m1_ack   = s_ack & m1_stb & m1_cyc;
      end
      default: ;  // idle: a stray slave ack reaches nobody
    endcase
  end

  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

endmodule

// File: tb/tb_wshb_arbiter2.sv
// tb/tb_wshb_arbiter2.sv - table-driven scoreboard bench for wshb_arbiter2 (MAX_BURST=4)

module tb_wshb_arbiter2;

  localparam logic [31:0] M0_ADR = 32'h1000_0040;
  localparam logic [31:0] M1_ADR = 32'h2000_0080;
  localparam logic [31:0] M0_DAT = 32'hA5A5_0000;
  localparam logic [31:0] M1_DAT = 32'h5A5A_FFFF;
`ifdef WSHB_ARB_M0_PRIORITY_EN
  localparam logic [1:0] TIE_G  = 2'b01;
  localparam int         HAND_N = 100;
`else
  localparam logic [1:0] TIE_G  = 2'b10;
  localparam int         HAND_N = 16;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_cyc = 1'b0, m0_stb = 1'b0, m1_cyc = 1'b0, m1_stb = 1'b0;
  logic        m0_we = 1'b1, m1_we = 1'b0;
  logic [3:0]  m0_sel = 4'hF, m1_sel = 4'h3;
  logic [31:0] m0_adr = M0_ADR, m1_adr = M1_ADR;
  logic [31:0] m0_dat_ms = M0_DAT, m1_dat_ms = M1_DAT;
  logic [31:0] m0_dat_sm, m1_dat_sm;
  logic        m0_ack, m1_ack;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_ms;
  logic [3:0]  s_sel;
  logic [31:0] s_dat_sm = '0;
  logic        s_ack = 1'b0;
  logic [1:0]  grant;

  always #5 clk = ~clk;

  wshb_arbiter2 #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_sel(m0_sel),
    .m0_dat_ms(m0_dat_ms), .m0_dat_sm(m0_dat_sm), .m0_ack(m0_ack),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_sel(m1_sel),
    .m1_dat_ms(m1_dat_ms), .m1_dat_sm(m1_dat_sm), .m1_ack(m1_ack),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
    .s_dat_ms(s_dat_ms), .s_dat_sm(s_dat_sm), .s_ack(s_ack), .grant(grant)
  );

  typedef struct {
    logic        rst_n, c0, s0, c1, s1, ack;
    logic [1:0]  g;
    logic        a0, a1;
    logic [31:0] dat;
    int          idx;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];
  vec_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   row_n  = 0;

  function automatic vec_t mk(input logic r, c0, s0, c1, s1, ak,
                              input logic [1:0] g, input logic a0, a1);
    vec_t v;
    v.rst_n = r; v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1; v.ack = ak;
    v.g = g; v.a0 = a0; v.a1 = a1; v.dat = '0; v.idx = 0;
    return v;
  endfunction

  function automatic logic [1:0] hand_g(input int k);
`ifdef WSHB_ARB_M0_PRIORITY_EN
    return 2'b01;
`else
    return (((k / 4) % 2) == 0) ? 2'b10 : 2'b01;
`endif
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d actual %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    rst_n  = v.rst_n;
    m0_cyc = v.c0; m0_stb = v.s0;
    m1_cyc = v.c1; m1_stb = v.s1;
    s_ack  = v.ack;
    s_dat_sm = $urandom;
    v.dat = s_dat_sm;
    v.idx = row_n;
    row_n++;
    sb.push_back(v);
  endtask

  // Scoreboard consumer: outputs are sampled mid-cycle, away from the edge.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk("grant",    mon_e.idx, {30'd0, grant}, {30'd0, mon_e.g});
      chk("m0_ack",   mon_e.idx, {31'd0, m0_ack}, {31'd0, mon_e.a0});
      chk("m1_ack",   mon_e.idx, {31'd0, m1_ack}, {31'd0, mon_e.a1});
      chk("s_cyc",    mon_e.idx, {31'd0, s_cyc},
          {31'd0, (mon_e.g == 2'b01) ? mon_e.c0 : (mon_e.g == 2'b10) ? mon_e.c1 : 1'b0});
      chk("s_stb",    mon_e.idx, {31'd0, s_stb},
          {31'd0, (mon_e.g == 2'b01) ? mon_e.s0 : (mon_e.g == 2'b10) ? mon_e.s1 : 1'b0});
      chk("s_we",     mon_e.idx, {31'd0, s_we}, {31'd0, (mon_e.g == 2'b01)});
      chk("s_adr",    mon_e.idx, s_adr,
          (mon_e.g == 2'b01) ? M0_ADR : (mon_e.g == 2'b10) ? M1_ADR : 32'd0);
      chk("s_dat_ms", mon_e.idx, s_dat_ms,
          (mon_e.g == 2'b01) ? M0_DAT : (mon_e.g == 2'b10) ? M1_DAT : 32'd0);
      chk("m0_dat_sm", mon_e.idx, m0_dat_sm, mon_e.dat);
      chk("m1_dat_sm", mon_e.idx, m1_dat_sm, mon_e.dat);
    end
  end

  initial begin
    // reset held 3 cycles with both masters requesting
    tbl.push_back(mk(0,1,1,1,1,0, 2'b00,0,0));
    tbl.push_back(mk(0,1,1,1,1,0, 2'b00,0,0));
    tbl.push_back(mk(0,1,1,1,1,0, 2'b00,0,0));
    tbl.push_back(mk(1,1,1,1,1,0, 2'b00,0,0));
    // round-robin: each master takes 2 acks then drops cyc for one cycle
    tbl.push_back(mk(1,1,1,1,1,1, 2'b01,1,0));
    tbl.push_back(mk(1,1,1,1,1,1, 2'b01,1,0));
    tbl.push_back(mk(1,0,0,1,1,0, 2'b01,0,0));
    tbl.push_back(mk(1,1,1,1,1,1, 2'b10,0,1));
    tbl.push_back(mk(1,1,1,1,1,1, 2'b10,0,1));
    tbl.push_back(mk(1,1,1,0,0,0, 2'b10,0,0));
    tbl.push_back(mk(1,1,1,1,1,1, 2'b01,1,0));
    tbl.push_back(mk(1,1,1,1,1,1, 2'b01,1,0));
    tbl.push_back(mk(1,0,0,1,1,0, 2'b01,0,0));
    tbl.push_back(mk(1,0,0,1,1,1, 2'b10,0,1));
    tbl.push_back(mk(1,0,0,1,1,1, 2'b10,0,1));
    tbl.push_back(mk(1,0,0,0,0,0, 2'b10,0,0));
    tbl.push_back(mk(1,0,0,0,0,0, 2'b00,0,0));
    // slave ack while idle, with and without a strobing master
    tbl.push_back(mk(1,0,0,0,0,1, 2'b00,0,0));
    tbl.push_back(mk(1,0,0,1,1,1, 2'b00,0,0));
    // single master m1: four reads, then release to idle
    tbl.push_back(mk(1,0,0,1,1,1, 2'b10,0,1));
    tbl.push_back(mk(1,0,0,1,1,1, 2'b10,0,1));
    tbl.push_back(mk(1,0,0,1,1,1, 2'b10,0,1));
    tbl.push_back(mk(1,0,0,1,1,1, 2'b10,0,1));
    tbl.push_back(mk(1,0,0,0,0,0, 2'b10,0,0));
    tbl.push_back(mk(1,0,0,0,0,0, 2'b00,0,0));
    // preemption: m1 bursts, m0 arrives mid-burst, exactly 4 m1 acks
    tbl.push_back(mk(1,0,0,1,1,0, 2'b00,0,0));
    tbl.push_back(mk(1,0,0,1,1,1, 2'b10,0,1));
    tbl.push_back(mk(1,1,1,1,1,1, 2'b10,0,1));
    tbl.push_back(mk(1,1,1,1,1,1, 2'b10,0,1));
    tbl.push_back(mk(1,1,1,1,1,1, 2'b10,0,1));
    tbl.push_back(mk(1,1,1,1,1,1, 2'b01,1,0));
    tbl.push_back(mk(1,1,1,1,1,0, 2'b01,0,0));
    tbl.push_back(mk(1,0,0,1,1,0, 2'b01,0,0));
    tbl.push_back(mk(1,0,0,1,1,1, 2'b10,0,1));
    // reset mid-transfer: grant drops the cycle after, no ack
    tbl.push_back(mk(1,0,0,1,1,1, 2'b10,0,1));
    tbl.push_back(mk(0,0,0,1,1,1, 2'b10,0,1));
    tbl.push_back(mk(1,0,0,1,1,1, 2'b00,0,0));
    tbl.push_back(mk(1,0,0,1,1,0, 2'b10,0,0));
    // m0 alone sets last=m0, then a simultaneous request from idle
    tbl.push_back(mk(1,0,0,0,0,0, 2'b10,0,0));
    tbl.push_back(mk(1,1,1,0,0,0, 2'b00,0,0));
    tbl.push_back(mk(1,1,1,0,0,0, 2'b01,0,0));
    tbl.push_back(mk(1,0,0,0,0,0, 2'b01,0,0));
    tbl.push_back(mk(1,1,1,1,1,0, 2'b00,0,0));
    tbl.push_back(mk(1,1,1,1,1,0, TIE_G,0,0));
    tbl.push_back(mk(1,1,1,1,1,0, TIE_G,0,0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Both masters saturate the bus with acks every cycle: round-robin hands
    // over every 4 acks; with m0 priority m0 keeps the bus throughout.
    for (int k = 0; k < HAND_N; k++) begin
      logic [1:0] g;
      g = hand_g(k);
      apply(mk(1,1,1,1,1,1, g, g[0], g[1]));
    end

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
